// File: rtl/pcm_arb_pkg.sv
// Shared definitions for the PCM port arbiter: FSM state codes, host
// opcodes and status-word bit positions.
package pcm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_t;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_CLR_ERR = 3'd3;

  localparam int RSP_TOGGLE = 3;
  localparam int RSP_BUSY   = 2;
  localparam int RSP_HALTED = 1;
  localparam int RSP_ERROR  = 0;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans the request vector starting at ptr and
// returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_CH = 2,
  parameter int IW   = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] sel;

  // Find the first asserted request at or after ptr, wrapping around.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel = IW'((int'(ptr) + i) % N_CH);
      if (!any && req[sel]) begin
        grant[sel] = 1'b1;
        idx        = sel;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcm_port_arbiter.sv
// Multi-channel arbiter in front of a single-port PCM on-chip RAM.
// One transaction at a time: IDLE picks a round-robin winner, ISSUE drives
// the RAM strobe, RDWAIT returns read data one cycle later. A toggle-strobed
// host command port can halt/resume granting and clear the sticky error.
module pcm_port_arbiter #(
  parameter int N_CH      = 2,
  parameter int AW        = 11,
  parameter int DW        = 16,
  parameter int MEM_WORDS = 2048
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            ch_req,
  input  logic [N_CH-1:0]            ch_we,
  input  logic [N_CH-1:0][AW-1:0]    ch_addr,
  input  logic [N_CH-1:0][DW-1:0]    ch_wdata,
  input  logic [N_CH-1:0][DW/8-1:0]  ch_be,
  output logic [N_CH-1:0]            ch_ack,
  output logic [DW-1:0]              ch_rdata,
  output logic [AW-1:0]              mem_address,
  output logic                       mem_chipselect,
  output logic                       mem_clken,
  output logic                       mem_write,
  output logic [DW-1:0]              mem_writedata,
  output logic [DW/8-1:0]            mem_byteenable,
  input  logic [DW-1:0]              mem_readdata,
  input  logic [3:0]                 ctl_cmd,
  output logic [3:0]                 rsp_status
);

  import pcm_arb_pkg::*;

  localparam int IW = idx_w(N_CH);
  localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_WORDS);

  arb_state_t state_q, state_d;

  logic [IW-1:0]   ptr_q;
  logic [N_CH-1:0] win_oh_q;
  logic            we_q;
  logic            oor_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] be_q;
  logic            halted_q;
  logic            err_q;
  logic            tog_q;

  logic [N_CH-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            grant_en;
  logic            ack_en;
  logic            cmd_fire;
  logic            err_set;

  rr_arbiter #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_rr (
    .req   (ch_req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign grant_en = (state_q == ST_IDLE) && !halted_q && grant_any;
  assign cmd_fire = (ctl_cmd[3] != tog_q);
  assign err_set  = (state_q == ST_ISSUE) && oor_q;

  // State register; an asynchronous reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Latch the winner's request and advance the round-robin pointer on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      win_oh_q <= '0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else if (grant_en) begin
      ptr_q    <= (grant_idx == IW'(N_CH-1)) ? '0 : grant_idx + IW'(1);
      win_oh_q <= grant;
      we_q     <= ch_we[grant_idx];
      oor_q    <= ({1'b0, ch_addr[grant_idx]} >= MEM_LIMIT);
      addr_q   <= ch_addr[grant_idx];
      wdata_q  <= ch_wdata[grant_idx];
      be_q     <= ch_be[grant_idx];
    end
  end

  // Host command port: act once per toggle of ctl_cmd[3]; an error raised in
  // the same cycle as CLR_ERR is kept so it cannot be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q    <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (cmd_fire) begin
        tog_q <= ctl_cmd[3];
        case (ctl_cmd[2:0])
          OP_RUN:  halted_q <= 1'b0;
          OP_HALT: halted_q <= 1'b1;
          default: ;
        endcase
      end
      if (err_set)
        err_q <= 1'b1;
      else if (cmd_fire && (ctl_cmd[2:0] == OP_CLR_ERR))
        err_q <= 1'b0;
    end
  end

  // Next-state and strobe decode; strobes and ack are zero unless named here.
  always_comb begin
    state_d        = state_q;
    mem_chipselect = 1'b0;
    mem_clken      = 1'b0;
    mem_write      = 1'b0;
    ack_en         = 1'b0;
    ch_rdata       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_en) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (oor_q) begin
          ack_en  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_chipselect = 1'b1;
          mem_clken      = 1'b1;
          mem_write      = we_q;
          if (we_q) begin
            ack_en  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RDWAIT;
          end
        end
      end
      ST_RDWAIT: begin
        ack_en   = 1'b1;
        ch_rdata = mem_readdata;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ch_ack         = ack_en ? win_oh_q : '0;
  assign mem_address    = mem_chipselect ? addr_q : '0;
  assign mem_writedata  = mem_write ? wdata_q : '0;
  assign mem_byteenable = mem_write ? be_q : '0;

  assign rsp_status[RSP_TOGGLE] = tog_q;
  assign rsp_status[RSP_BUSY]   = (state_q != ST_IDLE);
  assign rsp_status[RSP_HALTED] = halted_q;
  assign rsp_status[RSP_ERROR]  = err_q;

endmodule

// File: tb/tb_pcm_port_arbiter.sv
// Directed bench for pcm_port_arbiter with a 1024-word RAM model behind it.
// Expected acks are queued when a request is driven and retired by a monitor.
module tb_pcm_port_arbiter;

  localparam int N_CH = 2;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int MW   = 1024;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_CLR_ERR = 3'd3;

  logic                      clk;
  logic                      reset;
  logic [N_CH-1:0]           ch_req;
  logic [N_CH-1:0]           ch_we;
  logic [N_CH-1:0][AW-1:0]   ch_addr;
  logic [N_CH-1:0][DW-1:0]   ch_wdata;
  logic [N_CH-1:0][DW/8-1:0] ch_be;
  logic [N_CH-1:0]           ch_ack;
  logic [DW-1:0]             ch_rdata;
  logic [AW-1:0]             mem_address;
  logic                      mem_chipselect;
  logic                      mem_clken;
  logic                      mem_write;
  logic [DW-1:0]             mem_writedata;
  logic [DW/8-1:0]           mem_byteenable;
  logic [DW-1:0]             mem_readdata;
  logic [3:0]                ctl_cmd;
  logic [3:0]                rsp_status;

  typedef struct {
    int            ch;
    bit            rd;
    logic [DW-1:0] rdata;
  } sb_item_t;

  sb_item_t      sb[$];
  sb_item_t      mon_e;
  logic [DW-1:0] ram   [MW];
  logic [DW-1:0] shadow[MW];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int cs_cnt   = 0;
  int wr_cnt   = 0;

  pcm_port_arbiter #(
    .N_CH      (N_CH),
    .AW        (AW),
    .DW        (DW),
    .MEM_WORDS (MW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ch_req         (ch_req),
    .ch_we          (ch_we),
    .ch_addr        (ch_addr),
    .ch_wdata       (ch_wdata),
    .ch_be          (ch_be),
    .ch_ack         (ch_ack),
    .ch_rdata       (ch_rdata),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .ctl_cmd        (ctl_cmd),
    .rsp_status     (rsp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-masked writes, registered read data one cycle later.
  initial begin
    for (int i = 0; i < MW; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    mem_readdata = '0;
  end

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < DW/8; b++)
          if (mem_byteenable[b]) ram[mem_address[9:0]][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address[9:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_chipselect) cs_cnt++;
      if (mem_write) wr_cnt++;
      if (ch_ack != '0) begin
        ack_cnt++;
        check("ack_onehot", 32'($onehot(ch_ack)), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ch_ack), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ack_channel", 32'(ch_ack), 32'd1 << mon_e.ch);
          if (mon_e.rd) check("ack_rdata", 32'(ch_rdata), 32'(mon_e.rdata));
        end
      end
    end
  end

  // Drive one request and queue its expected completion.
  task automatic drive(input int ch, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
    sb_item_t e;
    e.ch    = ch;
    e.rd    = !we;
    e.rdata = '0;
    if (addr < AW'(MW)) begin
      if (we) begin
        for (int b = 0; b < DW/8; b++)
          if (be[b]) shadow[addr[9:0]][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        e.rdata = shadow[addr[9:0]];
      end
    end
    sb.push_back(e);
    ch_we[ch]    = we;
    ch_addr[ch]  = addr;
    ch_wdata[ch] = wdata;
    ch_be[ch]    = be;
    ch_req[ch]   = 1'b1;
  endtask

  // Latency = rising edge (counted from the drive edge) at which ack is captured.
  task automatic wait_ack(input int ch, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ch_ack[ch]) begin
        lat = i;
        break;
      end
    end
    check(tag, lat, exp_lat);
    @(posedge clk); #1;
    ch_req[ch] = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op);
    ctl_cmd = {~ctl_cmd[3], op};
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int base;
    int wr0;
    int cs0;

    reset    = 1'b1;
    ch_req   = '0;
    ch_we    = '0;
    ch_addr  = '0;
    ch_wdata = '0;
    ch_be    = '0;
    ctl_cmd  = 4'h0;
    repeat (3) tick();

    // Reset state
    check("rst_ack",    32'(ch_ack), 32'd0);
    check("rst_status", 32'(rsp_status), 32'd0);
    check("rst_cs",     32'(mem_chipselect), 32'd0);
    check("rst_rdata",  32'(ch_rdata), 32'd0);
    reset = 1'b0;
    tick();

    // Write then read back on ch0
    wr0 = wr_cnt;
    drive(0, 1'b1, 11'h005, 16'hBEEF, 2'b11);
    wait_ack(0, 2, "wr_lat");
    check("wr_pulses", wr_cnt - wr0, 1);
    check("ram_5", 32'(ram[5]), 32'hBEEF);
    drive(0, 1'b0, 11'h005, 16'h0000, 2'b00);
    wait_ack(0, 3, "rd_lat");

    // Partial byte write from ch1, read back on ch1
    drive(1, 1'b1, 11'h005, 16'h1234, 2'b01);
    wait_ack(1, 2, "be_wr_lat");
    drive(1, 1'b0, 11'h005, 16'h0000, 2'b00);
    wait_ack(1, 3, "be_rd_lat");

    // Out-of-range read: no RAM access, zero data, sticky error
    cs0 = cs_cnt;
    drive(1, 1'b0, 11'h7FF, 16'h0000, 2'b00);
    wait_ack(1, 2, "oor_lat");
    check("oor_no_cs", cs_cnt - cs0, 0);
    check("oor_err", 32'(rsp_status[0]), 32'd1);
    send_cmd(OP_CLR_ERR);
    check("clr_err", 32'(rsp_status[0]), 32'd0);

    // CLR_ERR landing in the same cycle as an out-of-range error: error stays
    drive(0, 1'b1, 11'h400, 16'hAAAA, 2'b11);
    tick();
    ctl_cmd = {~ctl_cmd[3], OP_CLR_ERR};
    tick();
    ch_req[0] = 1'b0;
    check("set_wins", 32'(rsp_status[0]), 32'd1);
    send_cmd(OP_CLR_ERR);
    check("clr_err2", 32'(rsp_status[0]), 32'd0);

    // HALT while a ch0 read is in flight; ch1 waits until RUN
    base = ack_cnt;
    drive(0, 1'b0, 11'h005, 16'h0000, 2'b00);
    tick();
    check("rd_strobe", {mem_chipselect, mem_clken, mem_write}, 3'b110);
    check("rd_addr", 32'(mem_address), 32'h005);
    ch_we[1]    = 1'b1;
    ch_addr[1]  = 11'h006;
    ch_wdata[1] = 16'h5A5A;
    ch_be[1]    = 2'b11;
    ch_req[1]   = 1'b1;
    tick();
    check("busy_rdwait", 32'(rsp_status[2]), 32'd1);
    ctl_cmd = {~ctl_cmd[3], OP_HALT};
    tick();
    ch_req[0] = 1'b0;
    check("halted_set", 32'(rsp_status[1]), 32'd1);
    check("halt_rd_acked", ack_cnt - base, 1);
    repeat (6) tick();
    check("halt_no_grant", ack_cnt - base, 1);
    check("halt_idle", 32'(rsp_status[2]), 32'd0);
    drive(1, 1'b1, 11'h006, 16'h5A5A, 2'b11);
    send_cmd(OP_RUN);
    check("run_clears", 32'(rsp_status[1]), 32'd0);
    wait_ack(1, 2, "run_ch1_lat");
    check("ram_6", 32'(ram[6]), 32'h5A5A);

    // NOP opcode only echoes the toggle
    check("pre_nop", 32'(rsp_status), 32'({ctl_cmd[3], 3'b000}));
    send_cmd(3'd5);
    check("nop_echo", 32'(rsp_status), 32'({ctl_cmd[3], 3'b000}));

    // Reset during ISSUE of a ch1 write
    ch_we[1]    = 1'b1;
    ch_addr[1]  = 11'h007;
    ch_wdata[1] = 16'hDEAD;
    ch_be[1]    = 2'b11;
    ch_req[1]   = 1'b1;
    tick();
    reset   = 1'b1;
    ctl_cmd = 4'h0;
    #1;
    check("mid_rst_ack",    32'(ch_ack), 32'd0);
    check("mid_rst_strobe", {mem_chipselect, mem_clken, mem_write}, 3'b000);
    check("mid_rst_addr",   32'(mem_address), 32'd0);
    check("mid_rst_status", 32'(rsp_status), 32'd0);
    ch_req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("no_ram_7", 32'(ram[7]), 32'd0);

    // Both channels requesting continuously: 0,1,0,1 starting at ch0
    base = ack_cnt;
    ch_we    = 2'b11;
    ch_addr  = {11'h011, 11'h010};
    ch_wdata = {16'h1111, 16'h0000};
    ch_be    = {2'b11, 2'b11};
    for (int k = 0; k < 4; k++) begin
      sb_item_t e;
      e.ch    = k % 2;
      e.rd    = 1'b0;
      e.rdata = '0;
      sb.push_back(e);
    end
    ch_req = 2'b11;
    for (int i = 0; i < 40 && ack_cnt < base + 4; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    ch_req = '0;
    check("rr_acks", ack_cnt - base, 4);
    repeat (3) tick();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
